ritc_idelay_loader: RTL

- Register-bus initiator for the RITC IDELAY control block.
- Holds a 78-entry delay table: 2 RITCs x 3 channels x (12 data bits + 1 clock).
- On start it pulses the IDELAYCTRL reset, polls the ready status, then writes and reads back every table entry in order.
- Sits between the housekeeping register space, which fills the table and starts the sequence, and the IDELAY control block's addr/dat/wr port.

---
 rtl/ritc_idelay_loader.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/ritc_idelay_loader.sv
// Register-bus initiator that resets the RITC IDELAYCTRL, waits for ready,
// then writes and reads back all 78 IDELAY taps from a local delay table.
module ritc_idelay_loader #(
    parameter int         RST_WAIT     = 32,
    parameter logic [5:0] RDY_MASK     = 6'h3F,
    parameter int         POLL_TIMEOUT = 4096,
    parameter int         LOAD_GAP     = 8,
    parameter int         RITC_SEL_BIT = 13
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        tbl_wr_i,
    input  logic [6:0]  tbl_addr_i,
    input  logic [5:0]  tbl_dat_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    output logic [6:0]  err_idx_o,
    output logic        ctl_addr_o,
    output logic [31:0] ctl_dat_o,
    output logic        ctl_wr_o,
    input  logic [31:0] ctl_dat_i
);

    localparam logic [15:0] RST_LAST  = 16'(RST_WAIT - 1);
    localparam logic [15:0] POLL_LAST = 16'(POLL_TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST  = 16'(LOAD_GAP - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RST_WR, S_RST_HOLD, S_POLL, S_LD_WR,
        S_LD_GAP, S_LD_CHK, S_NEXT, S_DONE, S_ERR
    } state_t;

    state_t      r_state, w_next;
    logic [15:0] r_cnt;
    logic        r_ritc;
    logic [1:0]  r_ch;
    logic [3:0]  r_bit;
    logic [5:0]  r_tbl [0:127];
    logic [31:0] r_ctl_dat;
    logic        r_err;
    logic [1:0]  r_err_code;
    logic [6:0]  r_err_idx;

    logic        w_start;
    logic        w_tbl_valid;
    logic [6:0]  w_idx;
    logic        w_ready;
    logic        w_rb_ok;
    logic        w_last;
    logic [31:0] w_word;
    logic        w_unused;

    assign w_start     = (r_state == S_IDLE) && start_i;
    assign w_tbl_valid = (tbl_addr_i[5:4] != 2'd3) &&
                         ((tbl_addr_i[3:0] < 4'd12) || (tbl_addr_i[3:0] == 4'd15));
    assign w_idx       = {r_ritc, r_ch, r_bit};
    assign w_ready     = (ctl_dat_i[5:0] & RDY_MASK) == RDY_MASK;
    assign w_last      = r_ritc && (r_ch == 2'd2) && (r_bit == 4'd15);
    assign w_rb_ok     = (ctl_dat_i[11:0] == w_word[11:0]) &&
                         (ctl_dat_i[RITC_SEL_BIT] == r_ritc);
    assign w_unused    = ^ctl_dat_i;

    always_comb begin
        w_word               = '0;
        w_word[5:0]          = r_tbl[w_idx];
        w_word[9:6]          = r_bit;
        w_word[11:10]        = r_ch;
        w_word[12]           = 1'b1;
        w_word[RITC_SEL_BIT] = r_ritc;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (start_i) w_next = S_RST_WR;
            S_RST_WR:   w_next = S_RST_HOLD;
            S_RST_HOLD: if (r_cnt == RST_LAST) w_next = S_POLL;
            S_POLL: begin
                if (w_ready)                 w_next = S_LD_WR;
                else if (r_cnt == POLL_LAST) w_next = S_ERR;
            end
            S_LD_WR:    w_next = S_LD_GAP;
            S_LD_GAP:   if (r_cnt == GAP_LAST) w_next = S_LD_CHK;
            S_LD_CHK:   w_next = w_rb_ok ? S_NEXT : S_ERR;
            S_NEXT:     w_next = w_last ? S_DONE : S_LD_WR;
            S_DONE:     w_next = S_IDLE;
            S_ERR:      w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Write data is driven live during the strobe and held afterwards.
    always_comb begin
        busy_o     = 1'b0;
        done_o     = 1'b0;
        ctl_wr_o   = 1'b0;
        ctl_addr_o = 1'b0;
        ctl_dat_o  = r_ctl_dat;
        case (r_state)
            S_RST_WR: begin
                busy_o    = 1'b1;
                ctl_wr_o  = 1'b1;
                ctl_dat_o = 32'd1;
            end
            S_RST_HOLD, S_POLL: busy_o = 1'b1;
            S_LD_WR: begin
                busy_o     = 1'b1;
                ctl_wr_o   = 1'b1;
                ctl_addr_o = 1'b1;
                ctl_dat_o  = w_word;
            end
            S_LD_GAP, S_LD_CHK, S_NEXT: begin
                busy_o     = 1'b1;
                ctl_addr_o = 1'b1;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    assign err_o      = r_err;
    assign err_code_o = r_err_code;
    assign err_idx_o  = r_err_idx;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt      <= '0;
            r_ritc     <= 1'b0;
            r_ch       <= '0;
            r_bit      <= '0;
            r_ctl_dat  <= '0;
            r_err      <= 1'b0;
            r_err_code <= '0;
            r_err_idx  <= '0;
        end else begin
            r_cnt <= (w_next != r_state) ? 16'd0 : r_cnt + 16'd1;
            if (ctl_wr_o) r_ctl_dat <= ctl_dat_o;
            if (w_start) begin
                r_err      <= 1'b0;
                r_err_code <= '0;
                r_err_idx  <= '0;
            end
            if (w_start || (r_state == S_POLL)) begin
                r_ritc <= 1'b0;
                r_ch   <= '0;
                r_bit  <= '0;
            end else if ((r_state == S_NEXT) && !w_last) begin
                // Bit order is 0..11 then the clock tap (15); bits 12..14 don't exist.
                if (r_bit == 4'd15) begin
                    r_bit <= '0;
                    if (r_ch == 2'd2) begin
                        r_ch   <= '0;
                        r_ritc <= 1'b1;
                    end else begin
                        r_ch <= r_ch + 2'd1;
                    end
                end else if (r_bit == 4'd11) begin
                    r_bit <= 4'd15;
                end else begin
                    r_bit <= r_bit + 4'd1;
                end
            end
            if ((w_next == S_ERR) && (r_state != S_ERR)) begin
                r_err      <= 1'b1;
                r_err_code <= (r_state == S_POLL) ? 2'd1 : 2'd2;
                r_err_idx  <= (r_state == S_POLL) ? 7'd0 : w_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 128; i++) r_tbl[i] <= '0;
        end else if (tbl_wr_i && w_tbl_valid && !busy_o && !w_start) begin
            r_tbl[tbl_addr_i] <= tbl_dat_i;
        end
    end

endmodule
